// File: rtl/mt9v034_ctrl_seq.sv
// mt9v034_ctrl_seq
// Camera control sequencer for the MT9V034 sensor, running in the 24 MHz
// camera clock domain. It generates the sensor power-on reset and boot delay,
// issues a fixed-width exposure pulse on a trigger-button rise, then follows
// the resulting frame on FRAME_VALID and reports completion or timeout.
//
// Ports:
//   clk          24 MHz clock, the same clock forwarded to sensor SYSCLK
//   reset_n      asynchronous active-low reset
//   rst_req      debounced camera-reset button level (clk domain)
//   trig_req     debounced trigger button level (clk domain)
//   frame_valid  sensor FRAME_VALID, asynchronous, synchronized internally
//   cam_reset_n  sensor RESET_BAR
//   cam_exposure sensor EXPOSURE trigger
//   ready        high while idle and able to accept a trigger
//   busy         high from exposure start until frame end or timeout
//   frame_done   one-cycle pulse at frame end
//   timeout      one-cycle pulse when a frame does not finish in time
//   frame_count  completed frames since the last reset sequence (wraps)
module mt9v034_ctrl_seq #(
    parameter int unsigned RST_CYCLES     = 32'd32,
    parameter int unsigned BOOT_CYCLES    = 32'd2400,
    parameter int unsigned TRIG_CYCLES    = 32'd240,
    parameter int unsigned TIMEOUT_CYCLES = 32'd2400000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rst_req,
    input  logic       trig_req,
    input  logic       frame_valid,
    output logic       cam_reset_n,
    output logic       cam_exposure,
    output logic       ready,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout,
    output logic [7:0] frame_count
);

    // One shared phase counter counts up from zero; a phase ends on the edge
    // where the counter already holds its last value (length - 1).
    localparam logic [23:0] RST_LAST  = 24'(RST_CYCLES - 32'd1);
    localparam logic [23:0] BOOT_LAST = 24'(BOOT_CYCLES - 32'd1);
    localparam logic [23:0] TRIG_LAST = 24'(TRIG_CYCLES - 32'd1);
    localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [2:0] {
        S_RESET_HOLD   = 3'd0,
        S_BOOT_WAIT    = 3'd1,
        S_IDLE         = 3'd2,
        S_TRIG         = 3'd3,
        S_WAIT_FV_RISE = 3'd4,
        S_WAIT_FV_FALL = 3'd5
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [23:0] cnt_r, cnt_nxt_s;

    logic rst_prev_r, trig_prev_r, rst_edge_r, trig_edge_r;
    logic fv_meta_r, fv_sync_r, fv_prev_r, fv_rise_r, fv_fall_r;
    logic done_s, timeout_s;

    logic       cam_reset_n_r, cam_exposure_r, ready_r, busy_r;
    logic       frame_done_r, timeout_r;
    logic [7:0] frame_count_r;
    logic       cam_reset_n_s, cam_exposure_s, ready_s, busy_s;
    logic [7:0] frame_count_s;

    // Input conditioning: button edge registers and FRAME_VALID synchronizer.
    // Button history resets to 1 so a level held through reset is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_prev_r  <= 1'b1;
            trig_prev_r <= 1'b1;
            rst_edge_r  <= 1'b0;
            trig_edge_r <= 1'b0;
            fv_meta_r   <= 1'b0;
            fv_sync_r   <= 1'b0;
            fv_prev_r   <= 1'b0;
            fv_rise_r   <= 1'b0;
            fv_fall_r   <= 1'b0;
        end else begin
            rst_prev_r  <= rst_req;
            trig_prev_r <= trig_req;
            rst_edge_r  <= rst_req & ~rst_prev_r;
            trig_edge_r <= trig_req & ~trig_prev_r;
            fv_meta_r   <= frame_valid;
            fv_sync_r   <= fv_meta_r;
            fv_prev_r   <= fv_sync_r;
            fv_rise_r   <= fv_sync_r & ~fv_prev_r;
            fv_fall_r   <= ~fv_sync_r & fv_prev_r;
        end
    end

    // State and phase counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_RESET_HOLD;
            cnt_r   <= 24'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; a camera-reset request overrides every state and
    // suppresses any completion or timeout decided in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + 24'd1;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        if (rst_edge_r) begin
            state_nxt_s = S_RESET_HOLD;
            cnt_nxt_s   = 24'd0;
        end else begin
            case (state_r)
                S_RESET_HOLD: begin
                    if (cnt_r == RST_LAST) begin
                        state_nxt_s = S_BOOT_WAIT;
                        cnt_nxt_s   = 24'd0;
                    end else begin
                        state_nxt_s = S_RESET_HOLD;
                    end
                end
                S_BOOT_WAIT: begin
                    if (cnt_r == BOOT_LAST) begin
                        state_nxt_s = S_IDLE;
                        cnt_nxt_s   = 24'd0;
                    end else begin
                        state_nxt_s = S_BOOT_WAIT;
                    end
                end
                S_IDLE: begin
                    cnt_nxt_s = 24'd0;
                    if (trig_edge_r) begin
                        state_nxt_s = S_TRIG;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_TRIG: begin
                    if (cnt_r == TRIG_LAST) begin
                        state_nxt_s = S_WAIT_FV_RISE;
                        cnt_nxt_s   = 24'd0;
                    end else begin
                        state_nxt_s = S_TRIG;
                    end
                end
                S_WAIT_FV_RISE: begin
                    // Counter keeps running into WAIT_FV_FALL: one budget per frame.
                    if (cnt_r == TO_LAST) begin
                        timeout_s   = 1'b1;
                        state_nxt_s = S_IDLE;
                        cnt_nxt_s   = 24'd0;
                    end else if (fv_rise_r) begin
                        state_nxt_s = S_WAIT_FV_FALL;
                    end else begin
                        state_nxt_s = S_WAIT_FV_RISE;
                    end
                end
                S_WAIT_FV_FALL: begin
                    // Frame end beats a timeout landing on the same cycle.
                    if (fv_fall_r) begin
                        done_s      = 1'b1;
                        state_nxt_s = S_IDLE;
                        cnt_nxt_s   = 24'd0;
                    end else if (cnt_r == TO_LAST) begin
                        timeout_s   = 1'b1;
                        state_nxt_s = S_IDLE;
                        cnt_nxt_s   = 24'd0;
                    end else begin
                        state_nxt_s = S_WAIT_FV_FALL;
                    end
                end
                default: begin
                    state_nxt_s = S_RESET_HOLD;
                    cnt_nxt_s   = 24'd0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered pins line up with it.
    always_comb begin
        cam_reset_n_s  = (state_nxt_s != S_RESET_HOLD);
        cam_exposure_s = (state_nxt_s == S_TRIG);
        ready_s        = (state_nxt_s == S_IDLE);
        busy_s         = (state_nxt_s == S_TRIG) || (state_nxt_s == S_WAIT_FV_RISE) ||
                         (state_nxt_s == S_WAIT_FV_FALL);
        frame_count_s  = frame_count_r;
        if (rst_edge_r) begin
            frame_count_s = 8'd0;
        end else if (done_s) begin
            frame_count_s = frame_count_r + 8'd1;
        end else begin
            frame_count_s = frame_count_r;
        end
    end

    // Output register: every pin leaves the block straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cam_reset_n_r  <= 1'b0;
            cam_exposure_r <= 1'b0;
            ready_r        <= 1'b0;
            busy_r         <= 1'b0;
            frame_done_r   <= 1'b0;
            timeout_r      <= 1'b0;
            frame_count_r  <= 8'd0;
        end else begin
            cam_reset_n_r  <= cam_reset_n_s;
            cam_exposure_r <= cam_exposure_s;
            ready_r        <= ready_s;
            busy_r         <= busy_s;
            frame_done_r   <= done_s;
            timeout_r      <= timeout_s;
            frame_count_r  <= frame_count_s;
        end
    end

    assign cam_reset_n  = cam_reset_n_r;
    assign cam_exposure = cam_exposure_r;
    assign ready        = ready_r;
    assign busy         = busy_r;
    assign frame_done   = frame_done_r;
    assign timeout      = timeout_r;
    assign frame_count  = frame_count_r;

endmodule

// File: tb/tb_mt9v034_ctrl_seq.sv
// Bench for mt9v034_ctrl_seq with short phase lengths (4/8/3/50 cycles).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mt9v034_ctrl_seq;

    logic       clk;
    logic       reset_n;
    logic       rst_req;
    logic       trig_req;
    logic       frame_valid;
    logic       cam_reset_n;
    logic       cam_exposure;
    logic       ready;
    logic       busy;
    logic       frame_done;
    logic       timeout;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;

    mt9v034_ctrl_seq #(
        .RST_CYCLES    (4),
        .BOOT_CYCLES   (8),
        .TRIG_CYCLES   (3),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rst_req     (rst_req),
        .trig_req    (trig_req),
        .frame_valid (frame_valid),
        .cam_reset_n (cam_reset_n),
        .cam_exposure(cam_exposure),
        .ready       (ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout     (timeout),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed output view: {cam_reset_n, cam_exposure, ready, busy, frame_done, timeout, frame_count}
    logic [13:0] outs;
    assign outs = {cam_reset_n, cam_exposure, ready, busy, frame_done, timeout, frame_count};

    typedef struct {
        int          n;      // cycles the inputs are held; outputs checked every cycle
        logic        rst;
        logic        trig;
        logic        fv;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [13:0] pk(input logic cr, input logic ex, input logic rd,
                                       input logic bs, input logic dn, input logic to,
                                       input logic [7:0] cnt);
        return {cr, ex, rd, bs, dn, to, cnt};
    endfunction

    function automatic vec_t mk(input int n, input logic r, input logic t, input logic f,
                                input logic [13:0] e);
        vec_t v;
        v.n = n; v.rst = r; v.trig = t; v.fv = f; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Trigger once and measure the exposure pulse width in cycles.
    task automatic trig_expose(output int exp_len);
        int w;
        trig_req = 1'b1;
        @(negedge clk);
        trig_req = 1'b0;
        w = 0;
        while (!cam_exposure && w < 10) begin
            @(negedge clk);
            w++;
        end
        exp_len = 0;
        while (cam_exposure && exp_len < 20) begin
            exp_len++;
            @(negedge clk);
        end
    endtask

    // Trigger and count cycles from end of exposure to the timeout pulse.
    task automatic timeout_run(input string tag);
        int          e, lat, dones;
        logic [7:0]  cnt0;
        cnt0 = frame_count;
        trig_expose(e);
        check({tag, "_exp_len"}, e, 3);
        lat = 0;
        dones = 0;
        while (!timeout && lat < 200) begin
            @(negedge clk);
            lat++;
            if (frame_done) dones++;
        end
        check({tag, "_latency"}, lat, 50);
        check({tag, "_no_done"}, dones, 0);
        check({tag, "_count"}, frame_count, cnt0);
        check({tag, "_ready"}, {ready, busy}, 2'b10);
        @(negedge clk);
        check({tag, "_pulse_width"}, timeout, 1'b0);
    endtask

    // One complete frame: exposure, short FRAME_VALID pulse, wait for frame_done.
    task automatic do_frame(input int idx);
        int e, w;
        trig_expose(e);
        frame_valid = 1'b1;
        repeat (3) @(negedge clk);
        frame_valid = 1'b0;
        w = 0;
        while (!frame_done && w < 30) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("frame%0d_done", idx), frame_done, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, bt, dn, e;

        // Stimulus/expectation table; trig_req is held high across reset release.
        tbl[0]  = mk(3,  1'b0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl[1]  = mk(2,  1'b0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl[2]  = mk(2,  1'b0, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl[3]  = mk(2,  1'b0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl[4]  = mk(2,  1'b0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl[5]  = mk(2,  1'b0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl[6]  = mk(2,  1'b0, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl[7]  = mk(1,  1'b0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl[8]  = mk(1,  1'b0, 1'b0, 1'b0, pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        tbl[9]  = mk(1,  1'b0, 1'b1, 1'b0, pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        tbl[10] = mk(1,  1'b0, 1'b0, 1'b0, pk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        tbl[11] = mk(1,  1'b0, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        tbl[12] = mk(20, 1'b0, 1'b0, 1'b1, pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        tbl[13] = mk(3,  1'b0, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
        tbl[14] = mk(1,  1'b0, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1));
        tbl[15] = mk(2,  1'b0, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));

        reset_n     = 1'b0;
        rst_req     = 1'b0;
        trig_req    = 1'b1;
        frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {18'd0, outs}, {18'd0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0)});

        // Power-on, ignored triggers, and one normal frame.
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                rst_req     = tbl[i].rst;
                trig_req    = tbl[i].trig;
                frame_valid = tbl[i].fv;
                @(negedge clk);
                check($sformatf("vec%0d_cyc%0d", i, c), {18'd0, outs}, {18'd0, tbl[i].exp});
            end
        end

        // Timeout with FRAME_VALID stuck low, then stuck high.
        timeout_run("to_fv_low");
        frame_valid = 1'b1;
        repeat (5) @(negedge clk);
        timeout_run("to_fv_high");
        frame_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("after_to_count", frame_count, 8'd1);

        // Camera-reset request in the middle of a frame.
        trig_expose(e);
        check("mid_exp_len", e, 3);
        frame_valid = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_busy", {busy, cam_reset_n}, 2'b11);
        rst_req     = 1'b1;
        frame_valid = 1'b0;
        @(negedge clk);
        check("rst_lat1", cam_reset_n, 1'b1);
        @(negedge clk);
        check("rst_lat2", {cam_reset_n, busy, frame_count}, {2'b00, 8'd0});
        dn = 0;
        lo = 1;
        while (!cam_reset_n && lo < 20) begin
            @(negedge clk);
            if (frame_done) dn++;
            if (!cam_reset_n) lo++;
        end
        check("rst_hold_len", lo, 4);
        bt = 0;
        while (!ready && bt < 30) begin
            @(negedge clk);
            if (frame_done) dn++;
            bt++;
        end
        check("boot_len", bt, 8);
        check("rst_no_done", dn, 0);
        check("rst_count", frame_count, 8'd0);
        rst_req = 1'b0;
        repeat (2) @(negedge clk);

        // frame_count wraps after 256 completed frames.
        for (int f = 0; f < 255; f++) do_frame(f);
        check("count_255", frame_count, 8'd255);
        do_frame(255);
        check("count_wrap", frame_count, 8'd0);
        check("wrap_ready", ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mt9v034_ctrl_seq.md
# mt9v034_ctrl_seq

Camera control sequencer for the MT9V034 sensor, clocked from the 24 MHz camera clock domain. It consumes the debounced camera-reset and trigger button levels and drives the sensor's RESET_BAR and EXPOSURE pins. It enforces a power-on reset, a boot delay, and a fixed-width exposure pulse, then tracks the resulting frame on FRAME_VALID and reports completion, timeout and frame count to downstream capture logic.

## Interface
- `RST_CYCLES`, 32: cycles `cam_reset_n` is held low per reset sequence (datasheet minimum 15).
- `BOOT_CYCLES`, 2400: cycles waited after reset release before `ready` (100 µs at 24 MHz).
- `TRIG_CYCLES`, 240: width of the `cam_exposure` high pulse (10 µs).
- `TIMEOUT_CYCLES`, 2400000: maximum cycles from end of exposure pulse to frame end (100 ms).
- Counter width: 24 bits shared by all phases. Every parameter value must lie in 1..2^24−1.
- `clk`  in  1  24 MHz clock, same clock that is forwarded to the sensor SYSCLK.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rst_req`  in  1  debounced camera-reset button level, synchronous to `clk`.
- `trig_req`  in  1  debounced trigger button level, synchronous to `clk`.
- `frame_valid`  in  1  sensor FRAME_VALID, asynchronous; passes through a 2-flop synchronizer.
- `cam_reset_n`  out  1  sensor RESET_BAR.
- `cam_exposure`  out  1  sensor EXPOSURE trigger.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in TRIG, WAIT_FV_RISE, WAIT_FV_FALL.
- `frame_done`  out  1  one-cycle pulse on frame end.
- `timeout`  out  1  one-cycle pulse on frame timeout.
- `frame_count`  out  8  completed frames since last reset sequence, wraps 255→0.

## Operation
- All outputs are registered. Reset values while `reset_n` = 0:
  - state = RESET_HOLD, counter = 0
  - `cam_reset_n` = 0, `cam_exposure` = 0
  - `ready` = 0, `busy` = 0, `frame_done` = 0, `timeout` = 0
  - `frame_count` = 0
  - edge-detect history for `rst_req`/`trig_req` = 1, synchronizer flops = 0
- Edge detection: a rising edge is input = 1 with previous sample = 0. Because history resets to 1, an input held high through reset fires no edge until it has gone low and high again.
- States and transitions:
  - RESET_HOLD: `cam_reset_n` = 0. After RST_CYCLES cycles, go to BOOT_WAIT.
  - BOOT_WAIT: `cam_reset_n` = 1. After BOOT_CYCLES cycles, go to IDLE.
  - IDLE: `ready` = 1. On a `trig_req` rise, go to TRIG.
  - TRIG: `cam_exposure` = 1. After TRIG_CYCLES cycles, go to WAIT_FV_RISE and clear the timeout counter.
  - WAIT_FV_RISE: on a synced `frame_valid` rise, go to WAIT_FV_FALL.
  - WAIT_FV_FALL: on a synced `frame_valid` fall, pulse `frame_done`, increment `frame_count`, go to IDLE.
  - Timeout: in either WAIT state, if the timeout counter reaches TIMEOUT_CYCLES, pulse `timeout` and go to IDLE. `frame_count` is unchanged. The timeout counter is not restarted on entry to WAIT_FV_FALL.
- `rst_req` rise has priority over everything. From any state it goes to RESET_HOLD, reloads the counter, drops `cam_exposure` the next cycle, and clears `frame_count`. A pending `frame_done`/`timeout` in the same cycle is suppressed.
- `trig_req` rises outside IDLE are discarded, not queued.
- If `frame_valid` is already high when WAIT_FV_RISE is entered, the block waits for a fresh rise.
- Simultaneous frame fall and timeout in the same cycle: `frame_done` wins and `timeout` stays 0.

## Timing
- Reset release at clock edge E0: `cam_reset_n` goes high after edge E(RST_CYCLES). `ready` goes high after edge E(RST_CYCLES+BOOT_CYCLES).
- Trigger-rise latency: `trig_req` is sampled high at edge T. `ready` falls and `cam_exposure` rises after edge T+1. `cam_exposure` stays high for exactly TRIG_CYCLES cycles.
- `frame_valid` path latency: 2 synchronizer cycles + 1 edge-detect cycle. `frame_done` asserts 3 cycles after the raw fall is first sampled. `ready` reasserts in the same cycle as `frame_done`.
- The `rst_req`-rise→`cam_reset_n` low latency is 2 cycles: edge register, then output register.

## Test plan
Directed scenarios, run with RST_CYCLES=4, BOOT_CYCLES=8, TRIG_CYCLES=3, TIMEOUT_CYCLES=50.
- Power-on: release `reset_n` -> `cam_reset_n` low for exactly 4 cycles, then `ready` high 8 cycles later. All other outputs stay 0.
- Normal frame: `trig_req` rise in IDLE -> `cam_exposure` high exactly 3 cycles. `frame_valid` high 20 cycles, then low -> one `frame_done` pulse 3 cycles after the fall, `frame_count` = 1, `ready` = 1.
- Timeout: trigger with `frame_valid` stuck low -> `timeout` pulse exactly 50 cycles after exposure ends, `frame_count` unchanged, back in IDLE. Repeat with `frame_valid` stuck high -> same timeout.
- Reset mid-frame: `rst_req` rise during WAIT_FV_FALL -> `cam_reset_n` low 2 cycles later, `frame_count` = 0, no `frame_done`, full 4+8 sequence repeats.
- Ignored triggers: `trig_req` rise during BOOT_WAIT and during TRIG -> no extra exposure pulse. Held `trig_req` across `reset_n` release -> no trigger until a low→high transition.
- Wrap: 256 completed frames -> `frame_count` reads 0.
